// File: rtl/rng_harvest_128.sv
// Consumer side of the 128-bit RNG generator. It warms the generator up, samples a word,
// applies a repetition/stuck health test and hands passing words out over valid/ready.
module rng_harvest_128 #(
    parameter int WARMUP_CYCLES = 16,
    parameter int REP_LIMIT     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] rng_data,
    output logic         rng_enable,
    input  logic         req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         health_fail
);

    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WARMUP = 3'd1;
    localparam logic [2:0] S_SAMPLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    logic [2:0]        state;
    logic [WARM_W-1:0] warm_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_next;
    logic [127:0]      sample_reg;
    logic [127:0]      prev_word;
    logic              prev_valid;
    logic              reject;

    // A word is rejected if it repeats the last accepted word or is stuck all-0/all-1.
    always_comb begin
        rep_next = rep_cnt + REP_W'(1);
        reject   = (prev_valid && (sample_reg == prev_word)) ||
                   (sample_reg == '0) || (&sample_reg);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            warm_cnt   <= '0;
            rep_cnt    <= '0;
            prev_valid <= 1'b0;
            prev_word  <= '0;
            out_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state    <= S_WARMUP;
                        warm_cnt <= '0;
                    end
                end
                // Counts 0..WARMUP_CYCLES, giving the W+3 edge req-to-valid latency.
                S_WARMUP: begin
                    if (warm_cnt == WARM_W'(WARMUP_CYCLES)) state <= S_SAMPLE;
                    else                                    warm_cnt <= warm_cnt + WARM_W'(1);
                end
                S_SAMPLE: state <= S_CHECK;
                S_CHECK: begin
                    if (reject) begin
                        rep_cnt <= rep_next;
                        state   <= (rep_next == REP_W'(REP_LIMIT)) ? S_FAIL : S_SAMPLE;
                    end else begin
                        rep_cnt    <= '0;
                        prev_word  <= sample_reg;
                        prev_valid <= 1'b1;
                        out_data   <= sample_reg;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) state <= S_IDLE;
                end
                S_FAIL:  state <= S_FAIL;
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: sample_reg carries no reset; SAMPLE always loads it before CHECK reads it.
    always_ff @(posedge clk) begin
        if (state == S_SAMPLE) sample_reg <= rng_data;
    end

    assign rng_enable  = (state == S_WARMUP) || (state == S_SAMPLE) || (state == S_CHECK);
    assign out_valid   = (state == S_HOLD);
    assign busy        = rng_enable || out_valid;
    assign health_fail = (state == S_FAIL);

endmodule
